// File: rtl/cbuf_pkg.sv
// Shared widths, FIFO sizing and FSM state encoding for the circular-buffer triggered readout.
package cbuf_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 26;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_POST  = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/cbuf_rd_fifo.sv
// 4-entry synchronous FIFO holding returned read words plus their last flag.
// Push is ignored when full and pop is ignored when empty; head word is visible combinationally.
module cbuf_rd_fifo #(
  parameter int W = cbuf_pkg::DATA_W + 1
) (
  input  logic                            adc_clk,
  input  logic                            reset_clk_adc_n,
  input  logic                            push_vld,
  input  logic [W-1:0]                    push_dat,
  input  logic                            pop_rdy,
  output logic [W-1:0]                    pop_dat,
  output logic [cbuf_pkg::FIFO_CNT_W-1:0] count,
  output logic                            full,
  output logic                            empty
);
  import cbuf_pkg::*;

  logic [W-1:0]          mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge adc_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/circ_buf_trig_readout.sv
// Captures a pre/post-trigger window from the ADC circular buffer and streams it out valid/ready.
// First word RD_LAT+1 cycles after READ starts; reads stall so FIFO plus in-flight never exceeds 4.
module circ_buf_trig_readout #(
  parameter int ADDR_W = cbuf_pkg::ADDR_W,
  parameter int DATA_W = cbuf_pkg::DATA_W,
  parameter int RD_LAT = 2,
  parameter int MISS_W = 8
) (
  input  logic              adc_clk,
  input  logic              reset_clk_adc_n,
  input  logic              cbuf_wr_en,
  input  logic [ADDR_W-1:0] circ_buf_wr_addr,
  input  logic              trig_pulse,
  input  logic [ADDR_W-1:0] pre_trig_len,
  input  logic [ADDR_W-1:0] window_len,
  output logic [ADDR_W-1:0] circ_buf_rd_addr,
  input  logic [DATA_W-1:0] circ_buf_rd_dat,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [MISS_W-1:0] trig_missed_cnt
);
  import cbuf_pkg::*;

  localparam int MW1 = MISS_W + 1;

  state_t                state;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ADDR_W-1:0]     post_left;
  logic [ADDR_W-1:0]     rd_left;
  logic [ADDR_W-1:0]     push_left;
  logic [RD_LAT-1:0]     vld_sr;
  logic [MISS_W-1:0]     miss_cnt;
  logic [MW1-1:0]        miss_sum;

  logic [ADDR_W-1:0]     pre_clamp;
  logic [ADDR_W-1:0]     start_addr;
  logic                  accept;
  logic                  reject;
  logic                  abort;
  logic                  issue;
  logic                  push_vld;
  logic                  push_last;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W-1:0] in_flight;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W:0]       fifo_head;

  assign pre_clamp  = (pre_trig_len < window_len) ? pre_trig_len : window_len;
  assign start_addr = circ_buf_wr_addr - pre_clamp;

  assign accept = (state == ST_IDLE) && trig_pulse && cbuf_wr_en && (window_len != '0);
  assign reject = trig_pulse && !accept;
  assign abort  = (state == ST_POST) && !cbuf_wr_en;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + FIFO_CNT_W'(vld_sr[i]);
    end
  end

  // Only issue when every outstanding read already has a FIFO slot reserved.
  assign issue = (state == ST_READ) && !fifo_full &&
                 ((fifo_count + in_flight) < FIFO_CNT_W'(FIFO_DEPTH));

  assign push_vld  = vld_sr[RD_LAT-1];
  assign push_last = (push_left == ADDR_W'(1));

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      post_left <= '0;
      rd_left   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_addr   <= start_addr;
            post_left <= window_len - pre_clamp;
            rd_left   <= window_len;
            state     <= (window_len != pre_clamp) ? ST_POST : ST_READ;
          end
        end
        ST_POST: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            post_left <= post_left - 1'b1;
            if (post_left == ADDR_W'(1)) state <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            rd_left <= rd_left - 1'b1;
            if (rd_left == ADDR_W'(1)) state <= ST_DRAIN;
          end
        end
        default: begin
          if ((in_flight == '0) && fifo_empty) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      push_left <= '0;
    end else if (accept) begin
      push_left <= window_len;
    end else if (push_vld) begin
      push_left <= push_left - 1'b1;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // A rejected trigger and a POST abort can land in the same cycle.
  assign miss_sum = {1'b0, miss_cnt} + MW1'(reject) + MW1'(abort);

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      miss_cnt <= '0;
    end else if (miss_sum[MISS_W]) begin
      miss_cnt <= '1;
    end else begin
      miss_cnt <= miss_sum[MISS_W-1:0];
    end
  end

  cbuf_rd_fifo #(
    .W (DATA_W + 1)
  ) u_rd_fifo (
    .adc_clk         (adc_clk),
    .reset_clk_adc_n (reset_clk_adc_n),
    .push_vld        (push_vld),
    .push_dat        ({push_last, circ_buf_rd_dat}),
    .pop_rdy         (out_ready),
    .pop_dat         (fifo_head),
    .count           (fifo_count),
    .full            (fifo_full),
    .empty           (fifo_empty)
  );

  assign circ_buf_rd_addr = rd_addr;
  assign out_valid        = !fifo_empty;
  assign out_dat          = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_last         = !fifo_empty && fifo_head[DATA_W];
  assign busy             = (state != ST_IDLE);
  assign trig_missed_cnt  = miss_cnt;

endmodule
